// File: rtl/falling_grid_engine_pkg.sv
// Shared types and constants for the falling-object playfield engine.
package falling_grid_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FALL,
    ST_SPAWN,
    ST_DRAW,
    ST_DONE
  } state_t;

  // Galois feedback taps for the 16-bit spawn LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // Lane select width taken from the low LFSR bits
  localparam int LANE_W = 5;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/falling_grid_engine_if.sv
// Pixel stream and draw handshake between the engine, control and vga_adapter.
interface falling_grid_engine_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic               draw_req;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               plot;
  logic               finish_drawing;
  logic               busy;

  modport master (input draw_req, output x, y, color, plot, finish_drawing, busy);
  modport slave  (output draw_req, input x, y, color, plot, finish_drawing, busy);
endinterface

// File: rtl/falling_grid_engine_lfsr_spawn.sv
// 16-bit Galois LFSR supplying the spawn lane; free-runs while the game is enabled.
module lfsr_spawn
  import falling_grid_engine_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [LANE_W-1:0] lane
);
  logic [15:0] lfsr_q;

  // Advance once per enabled cycle; reload the seed on reset
  always_ff @(posedge clock) begin
    if (reset)       lfsr_q <= SEED;
    else if (enable) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lane = lfsr_q[LANE_W-1:0];
endmodule

// File: rtl/falling_grid_engine.sv
// Playfield engine: occupancy grid, fall/spawn updates, catch/miss scoring and
// full-frame pixel streaming. Fall/spawn are deferred while a frame is drawn.
module falling_grid_engine
  import falling_grid_engine_pkg::*;
#(
  parameter int                 COLS      = 20,
  parameter int                 ROWS      = 15,
  parameter int                 CELL      = 8,
  parameter int                 X_W       = 8,
  parameter int                 Y_W       = 7,
  parameter int                 COLOR_W   = 3,
  parameter logic [COLOR_W-1:0] OBJ_COLOR = 3'b110,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 3'b000,
  parameter logic [15:0]        SEED      = 16'hACE1,
  parameter int                 CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fall_tick,
  input  logic                 spawn_tick,
  input  logic [LANE_W-1:0]    player_col,
  falling_grid_engine_if.master pix,
  output logic [CNT_W-1:0]     catch_count,
  output logic [CNT_W-1:0]     miss_count
);
  localparam int CELLS = ROWS * COLS;
  localparam int PX_W  = $clog2(CELL + 1);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int IDX_W = $clog2(CELLS + 1);

  state_t            st, st_n;
  logic              pend_fall, pend_spawn;
  logic [CELLS-1:0]  grid;          // row r occupies bits [r*COLS +: COLS]
  logic [PX_W-1:0]   px_q, py_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [LANE_W-1:0] lane;
  logic              last_pix;
  logic [COLS-1:0]   bottom, pmask;
  logic [IDX_W-1:0]  cell_idx;

  function automatic int unsigned popcount(input logic [COLS-1:0] v);
    int unsigned n = 0;
    for (int i = 0; i < COLS; i++) n += 32'(v[i]);
    return n;
  endfunction

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned inc);
    int unsigned s = 32'(a) + inc;
    return (s > (2**CNT_W - 1)) ? '1 : CNT_W'(s);
  endfunction

  lfsr_spawn #(.SEED(SEED)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .lane   (lane)
  );

  assign bottom   = grid[CELLS-1 -: COLS];
  // An out-of-range catcher lane catches nothing, so every bottom bit is a miss
  assign pmask    = ({1'b0, player_col} < 6'(COLS)) ? (COLS'(1) << player_col) : '0;
  assign last_pix = (px_q == PX_W'(CELL-1)) && (py_q == PX_W'(CELL-1)) &&
                    (col_q == COL_W'(COLS-1)) && (row_q == ROW_W'(ROWS-1));
  assign cell_idx = IDX_W'(32'(row_q) * COLS + 32'(col_q));
  assign pix.busy = (st != ST_IDLE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) st <= ST_IDLE;
    else       st <= st_n;
  end

  // Next state: pending fall beats pending spawn beats a new draw request
  always_comb begin
    st_n = st;
    case (st)
      ST_IDLE: begin
        if (pend_fall)         st_n = ST_FALL;
        else if (pend_spawn)   st_n = ST_SPAWN;
        else if (pix.draw_req) st_n = ST_DRAW;
      end
      ST_FALL, ST_SPAWN: st_n = ST_IDLE;
      ST_DRAW: if (last_pix) st_n = ST_DONE;
      ST_DONE: st_n = ST_IDLE;
      default: st_n = ST_IDLE;
    endcase
  end

  // Latch enabled ticks; a new tick wins over the clear in its service cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_fall  <= 1'b0;
      pend_spawn <= 1'b0;
    end else begin
      pend_fall  <= (pend_fall  && (st != ST_FALL))  || (enable && fall_tick);
      pend_spawn <= (pend_spawn && (st != ST_SPAWN)) || (enable && spawn_tick);
    end
  end

  // Grid shift/spawn and scoring of the row leaving the bottom
  always_ff @(posedge clock) begin
    if (reset) begin
      grid        <= '0;
      catch_count <= '0;
      miss_count  <= '0;
    end else if (st == ST_FALL) begin
      grid        <= {grid[CELLS-COLS-1:0], {COLS{1'b0}}};
      catch_count <= sat_add(catch_count, popcount(bottom & pmask));
      miss_count  <= sat_add(miss_count, popcount(bottom & ~pmask));
    end else if ((st == ST_SPAWN) && ({1'b0, lane} < 6'(COLS))) begin
      grid[lane] <= 1'b1;
    end
  end

  // Pixel walk (px fastest, then py, col, row) with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      px_q <= '0;  py_q <= '0;  col_q <= '0;  row_q <= '0;
      pix.x <= '0;  pix.y <= '0;  pix.color <= '0;
      pix.plot <= 1'b0;
      pix.finish_drawing <= 1'b0;
    end else begin
      pix.plot           <= 1'b0;
      pix.finish_drawing <= (st == ST_DONE);
      if (st == ST_DRAW) begin
        pix.x     <= X_W'(32'(col_q) * CELL + 32'(px_q));
        pix.y     <= Y_W'(32'(row_q) * CELL + 32'(py_q));
        pix.color <= grid[cell_idx] ? OBJ_COLOR : BG_COLOR;
        pix.plot  <= 1'b1;
        if (px_q == PX_W'(CELL-1)) begin
          px_q <= '0;
          if (py_q == PX_W'(CELL-1)) begin
            py_q <= '0;
            if (col_q == COL_W'(COLS-1)) begin
              col_q <= '0;
              row_q <= (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else begin
            py_q <= py_q + 1'b1;
          end
        end else begin
          px_q <= px_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_falling_grid_engine.sv
// Bench for falling_grid_engine: a grid/score/pixel-index model checked against
// two instances (default counters and 2-bit counters) every cycle, plus
// hand-computed scenario expectations.
module tb_falling_grid_engine;
  localparam int COLS = 20;
  localparam int ROWS = 15;
  localparam int CELL = 8;
  localparam int NPIX = COLS * ROWS * CELL * CELL;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int M_IDLE = 0, M_FALL = 1, M_SPAWN = 2, M_DRAW = 3, M_DONE = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, fall_tick = 1'b0, spawn_tick = 1'b0;
  logic [4:0] player_col = 5'd0;
  logic [7:0] catch_count, miss_count;
  logic [1:0] catch2, miss2;

  falling_grid_engine_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) pif ();
  falling_grid_engine_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) pif2 ();
  assign pif2.draw_req = pif.draw_req;

  falling_grid_engine dut (
    .clock(clock), .reset(reset), .enable(enable), .fall_tick(fall_tick),
    .spawn_tick(spawn_tick), .player_col(player_col), .pix(pif),
    .catch_count(catch_count), .miss_count(miss_count));

  falling_grid_engine #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .fall_tick(fall_tick),
    .spawn_tick(spawn_tick), .player_col(player_col), .pix(pif2),
    .catch_count(catch2), .miss_count(miss2));

  always #5 clock = ~clock;

  // ---------------- model ----------------
  bit          m_grid [ROWS][COLS];
  bit          m_pf, m_ps;
  int          m_mode, m_pix;
  logic [15:0] m_lfsr;
  int          e_x, e_y, e_color, e_catch, e_miss, e_catch2, e_miss2;
  bit          e_plot, e_fin;

  int n_pass = 0, n_chk = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step();
    int old_mode, caught, missed, px, py, c, r;
    bit pf, ps;
    if (reset) begin
      foreach (m_grid[i, j]) m_grid[i][j] = 1'b0;
      m_pf = 0; m_ps = 0; m_mode = M_IDLE; m_pix = 0; m_lfsr = SEED;
      e_x = 0; e_y = 0; e_color = 0; e_plot = 0; e_fin = 0;
      e_catch = 0; e_miss = 0; e_catch2 = 0; e_miss2 = 0;
    end else begin
      old_mode = m_mode; pf = m_pf; ps = m_ps;
      e_plot = 0; e_fin = 0;
      m_pf = (pf && old_mode != M_FALL) || (enable && fall_tick);
      m_ps = (ps && old_mode != M_SPAWN) || (enable && spawn_tick);
      case (old_mode)
        M_IDLE: begin
          if (pf) m_mode = M_FALL;
          else if (ps) m_mode = M_SPAWN;
          else if (pif.draw_req) begin m_mode = M_DRAW; m_pix = 0; end
        end
        M_FALL: begin
          caught = 0; missed = 0;
          for (int k = 0; k < COLS; k++)
            if (m_grid[ROWS-1][k]) begin
              if (k == int'(player_col)) caught++; else missed++;
            end
          for (int rr = ROWS - 1; rr > 0; rr--)
            for (int k = 0; k < COLS; k++) m_grid[rr][k] = m_grid[rr-1][k];
          for (int k = 0; k < COLS; k++) m_grid[0][k] = 1'b0;
          e_catch  = sat(e_catch + caught, 255);
          e_miss   = sat(e_miss + missed, 255);
          e_catch2 = sat(e_catch2 + caught, 3);
          e_miss2  = sat(e_miss2 + missed, 3);
          m_mode = M_IDLE;
        end
        M_SPAWN: begin
          if (int'(m_lfsr[4:0]) < COLS) m_grid[0][m_lfsr[4:0]] = 1'b1;
          m_mode = M_IDLE;
        end
        M_DRAW: begin
          px = m_pix % CELL;
          py = (m_pix / CELL) % CELL;
          c  = (m_pix / (CELL * CELL)) % COLS;
          r  = m_pix / (CELL * CELL * COLS);
          e_x = c * CELL + px; e_y = r * CELL + py;
          e_color = m_grid[r][c] ? 6 : 0;
          e_plot = 1;
          m_pix++;
          if (m_pix == NPIX) m_mode = M_DONE;
        end
        default: begin
          e_fin = 1;
          m_mode = M_IDLE;
        end
      endcase
      if (enable) m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  // ---------------- per-cycle compare and frame statistics ----------------
  bit seen [160][120];
  int cyc_n = 0, f_plots = 0, f_dup = 0, f_obj_in = 0, f_obj_out = 0, f_fin = 0;
  int last_plot_cyc = 0, fin_cyc = 0;

  task automatic clear_frame();
    foreach (seen[i, j]) seen[i][j] = 1'b0;
    f_plots = 0; f_dup = 0; f_obj_in = 0; f_obj_out = 0; f_fin = 0;
  endtask

  initial forever begin
    @(negedge clock);
    cyc_n++;
    if (chk_on) begin
      chk("plot", pif.plot, e_plot);
      chk("finish", pif.finish_drawing, e_fin);
      chk("busy", pif.busy, m_mode != M_IDLE);
      chk("x", pif.x, e_x);
      chk("y", pif.y, e_y);
      chk("color", pif.color, e_color);
      chk("catch", catch_count, e_catch);
      chk("miss", miss_count, e_miss);
      chk("plot2", pif2.plot, e_plot);
      chk("finish2", pif2.finish_drawing, e_fin);
      chk("busy2", pif2.busy, m_mode != M_IDLE);
      chk("xy2", {pif2.x, pif2.y, pif2.color}, {pif.x, pif.y, pif.color});
      chk("catch2", catch2, e_catch2);
      chk("miss2", miss2, e_miss2);
      if (pif.plot) begin
        f_plots++; last_plot_cyc = cyc_n;
        if (pif.x < 160 && pif.y < 120) begin
          if (seen[pif.x][pif.y]) f_dup++;
          seen[pif.x][pif.y] = 1'b1;
        end else f_dup++;
        if (pif.color == 3'b110) begin
          if (pif.x >= 8 && pif.x <= 15 && pif.y <= 7) f_obj_in++; else f_obj_out++;
        end
      end
      if (pif.finish_drawing) begin f_fin++; fin_cyc = cyc_n; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_mode != M_IDLE || m_pf || m_ps) && n < limit) begin cyc(); n++; end
    if (n >= limit) chk("wait_idle_timeout", n, 0);
  endtask

  task automatic do_fall(input int pc);
    player_col = 5'(pc); enable = 1; fall_tick = 1;
    cyc();
    fall_tick = 0; enable = 0;
    wait_idle(20);
  endtask

  // Run the LFSR until the value it will hold at SPAWN has the wanted lane
  task automatic spawn_at(input int lane);
    logic [15:0] nx;
    int n = 0;
    enable = 1;
    nx = lfsr_step(m_lfsr);
    while (int'(nx[4:0]) != lane && n < 5000) begin cyc(); n++; nx = lfsr_step(m_lfsr); end
    if (n >= 5000) chk("spawn_search_timeout", n, 0);
    spawn_tick = 1;
    cyc();
    spawn_tick = 0; enable = 0;
    wait_idle(20);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    pif.draw_req = 1'b0;
    cyc();
    chk_on = 1'b1;
    repeat (2) cyc();
    chk("rst_plot", pif.plot, 0);
    chk("rst_busy", pif.busy, 0);
    chk("rst_catch", catch_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_x", pif.x, 0);
    chk("lfsr_model_pin", lfsr_step(SEED), 16'hE270);
    reset = 1'b0;
    cyc();

    // Single spawn at lane 3 travels 15 rows and is caught
    spawn_at(3);
    for (int i = 0; i < 14; i++) do_fall(31);
    chk("lane3_not_yet_scored", catch_count + miss_count, 0);
    do_fall(3);
    chk("lane3_caught", catch_count, 1);
    chk("lane3_no_miss", miss_count, 0);
    for (int i = 0; i < 15; i++) do_fall(31);
    chk("grid_empty_after_catch", miss_count, 0);

    // Lane 25 is off the grid: no object appears, spawn request is consumed
    spawn_at(25);
    chk("skip_not_busy", pif.busy, 0);
    for (int i = 0; i < 15; i++) do_fall(31);
    chk("skip_no_miss", miss_count, 0);

    // Five objects in one row, catcher off-grid: five misses, 2-bit counter sticks at 3
    spawn_at(4); spawn_at(5); spawn_at(6); spawn_at(8); spawn_at(9);
    for (int i = 0; i < 15; i++) do_fall(31);
    chk("miss5", miss_count, 5);
    chk("miss_sat2", miss2, 3);
    chk("catch_w2", catch2, 1);

    // Bottom row {2,7} with catcher at 7: one catch, one miss
    spawn_at(2); spawn_at(7);
    for (int i = 0; i < 14; i++) do_fall(31);
    do_fall(7);
    chk("pair_catch", catch_count, 2);
    chk("pair_miss", miss_count, 6);
    chk("pair_catch2", catch2, 2);
    chk("pair_miss_sat2", miss2, 3);

    // Object at row 0 col 1; ticks with enable low are dropped
    spawn_at(1);
    fall_tick = 1; spawn_tick = 1;
    repeat (2) cyc();
    fall_tick = 0; spawn_tick = 0;
    repeat (3) cyc();
    chk("disabled_tick_idle", pif.busy, 0);

    // Full frame with fall+spawn ticks arriving mid-draw
    clear_frame();
    pif.draw_req = 1; cyc(); pif.draw_req = 0;
    n = 0;
    while (f_plots < 1000 && n < 2000) begin cyc(); n++; end
    enable = 1; fall_tick = 1; spawn_tick = 1;
    cyc();
    enable = 0; fall_tick = 0; spawn_tick = 0;
    chk("draw_continues", pif.busy, 1);
    n = 0;
    while (f_fin == 0 && n < 25000) begin cyc(); n++; end
    chk("deferred_fall_busy", pif.busy, 1);
    cyc();
    chk("between_idle", pif.busy, 0);
    cyc();
    chk("deferred_spawn_busy", pif.busy, 1);
    cyc();
    chk("after_spawn_idle", pif.busy, 0);
    chk("frame_plots", f_plots, 19200);
    chk("frame_dups", f_dup, 0);
    chk("obj_pixels_in_cell", f_obj_in, 64);
    chk("obj_pixels_elsewhere", f_obj_out, 0);
    chk("finish_once", f_fin, 1);
    chk("finish_after_last", fin_cyc - last_plot_cyc, 1);

    // Reset around pixel 500 aborts the frame
    clear_frame();
    pif.draw_req = 1; cyc(); pif.draw_req = 0;
    n = 0;
    while (f_plots < 500 && n < 2000) begin cyc(); n++; end
    reset = 1;
    cyc();
    chk("abort_plot", pif.plot, 0);
    chk("abort_busy", pif.busy, 0);
    chk("abort_catch", catch_count, 0);
    chk("abort_miss", miss_count, 0);
    reset = 0;
    repeat (40) cyc();
    chk("abort_no_finish", f_fin, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
